wb_commit: RTL and testbench

//  Register-file write initiator for the RISC-V core. Merges in-order pipeline writebacks with
//  out-of-order late results (load/UART/mul) into one registered write port (rf_we/rf_wa/rf_wd).

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_late_fifo.sv | 64 ++++++
 rtl/wb_commit.sv | 146 ++++++++++++++
 tb/tb_wb_commit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and sizes for the writeback commit block.
// The optional WB_BYPASS_EN macro is consumed by wb_commit, not by this package.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_AW     = 5;
    localparam int NREGS      = 32;
    localparam int LATE_DEPTH = 4;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [XLEN-1:0]   wd;
    } wb_req_t;

endpackage

// File: rtl/wb_late_fifo.sv
// Synchronous FIFO of late writeback requests.
// Pointers carry an extra wrap bit so full and empty are told apart without a separate counter.
module wb_late_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t       mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   wptr_d;
    logic [AW:0]   rptr_q;
    logic [AW:0]   rptr_d;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count   = wptr_q - rptr_q;
    assign head    = mem_q[rptr_q[AW-1:0]];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: nothing is read until the pointers say an entry is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_commit.sv
// Merges pipeline writebacks and late results into one registered register-file write port,
// and tracks pending late destinations for hazard detection. Define WB_BYPASS_EN for forwarding.
module wb_commit #(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int LATE_DEPTH = wb_pkg::LATE_DEPTH
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [4:0]      pipe_wa,
    input  logic [XLEN-1:0] pipe_wd,
    input  logic            late_valid,
    output logic            late_ready,
    input  logic [4:0]      late_wa,
    input  logic [XLEN-1:0] late_wd,
    input  logic            sb_set,
    input  logic [4:0]      sb_set_wa,
    input  logic [4:0]      q_ra1,
    input  logic [4:0]      q_ra2,
    input  logic [4:0]      q_wa,
    output logic            hazard,
    output logic            drain_req,
    output logic            rf_we,
    output logic [4:0]      rf_wa,
    output logic [XLEN-1:0] rf_wd,
    output logic            fwd1_hit,
    output logic [XLEN-1:0] fwd1_data,
    output logic            fwd2_hit,
    output logic [XLEN-1:0] fwd2_data
);

    import wb_pkg::*;

    localparam int CW = $clog2(LATE_DEPTH) + 1;

    wb_req_t          late_req;
    wb_req_t          head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push_en;
    logic             pipe_sel;
    logic             pop_en;

    logic             rf_we_q;
    logic             rf_we_d;
    logic [4:0]       rf_wa_q;
    logic [4:0]       rf_wa_d;
    logic [XLEN-1:0]  rf_wd_q;
    logic [XLEN-1:0]  rf_wd_d;
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Writes to x0 complete the handshake but never occupy a FIFO slot.
    assign late_req.wa = late_wa;
    assign late_req.wd = late_wd;
    assign late_ready  = !fifo_full;
    assign push_en     = late_valid && !fifo_full && (late_wa != '0);
    assign pipe_sel    = pipe_we && (pipe_wa != '0);
    assign pop_en      = !pipe_sel && !fifo_empty;
    assign drain_req   = (fifo_count == CW'(LATE_DEPTH));

    wb_late_fifo #(
        .DEPTH(LATE_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_en),
        .push_data(late_req),
        .pop      (pop_en),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        rf_we_d = 1'b0;
        rf_wa_d = rf_wa_q;
        rf_wd_d = rf_wd_q;
        if (pipe_sel) begin
            rf_we_d = 1'b1;
            rf_wa_d = pipe_wa;
            rf_wd_d = pipe_wd;
        end else if (pop_en) begin
            rf_we_d = 1'b1;
            rf_wa_d = head.wa;
            rf_wd_d = head.wd;
        end
    end

    // The set is applied after the clear so a same-edge dispatch keeps the register pending.
    always_comb begin
        pending_d = pending_q;
        if (pop_en) begin
            pending_d[head.wa] = 1'b0;
        end
        if (sb_set && (sb_set_wa != '0)) begin
            pending_d[sb_set_wa] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_wa_q   <= '0;
            rf_wd_q   <= '0;
            pending_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_wa_q   <= rf_wa_d;
            rf_wd_q   <= rf_wd_d;
            pending_q <= pending_d;
        end
    end

    assign rf_we  = rf_we_q;
    assign rf_wa  = rf_wa_q;
    assign rf_wd  = rf_wd_q;
    assign hazard = pending_q[q_ra1] | pending_q[q_ra2] | pending_q[q_wa];

`ifdef WB_BYPASS_EN
    assign fwd1_hit  = rf_we_q && (rf_wa_q != '0) && (rf_wa_q == q_ra1);
    assign fwd1_data = rf_wd_q;
    assign fwd2_hit  = rf_we_q && (rf_wa_q != '0) && (rf_wa_q == q_ra2);
    assign fwd2_data = rf_wd_q;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_hit  = 1'b0;
    assign fwd2_data = '0;
`endif

`ifndef SYNTHESIS
    // Re-dispatch is only legal when the earlier result retires on the same edge.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(sb_set && (sb_set_wa != '0) && pending_q[sb_set_wa]
                      && !(pop_en && (head.wa == sb_set_wa))));
            assert (!(pipe_sel && pending_q[pipe_wa]));
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Scoreboard bench for wb_commit: stimulus queues expected rf writes, a monitor checks them.
module tb_wb_commit;

    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_wa = '0;
    logic [31:0] pipe_wd = '0;
    logic        late_valid = 1'b0;
    logic        late_ready;
    logic [4:0]  late_wa = '0;
    logic [31:0] late_wd = '0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_wa = '0;
    logic [4:0]  q_ra1 = '0;
    logic [4:0]  q_ra2 = '0;
    logic [4:0]  q_wa = '0;
    logic        hazard;
    logic        drain_req;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        fwd1_hit;
    logic [31:0] fwd1_data;
    logic        fwd2_hit;
    logic [31:0] fwd2_data;

    int checks = 0;
    int failures = 0;
    wb_req_t expQ[$];

    wb_commit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pipe_we   (pipe_we),
        .pipe_wa   (pipe_wa),
        .pipe_wd   (pipe_wd),
        .late_valid(late_valid),
        .late_ready(late_ready),
        .late_wa   (late_wa),
        .late_wd   (late_wd),
        .sb_set    (sb_set),
        .sb_set_wa (sb_set_wa),
        .q_ra1     (q_ra1),
        .q_ra2     (q_ra2),
        .q_wa      (q_wa),
        .hazard    (hazard),
        .drain_req (drain_req),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .fwd1_hit  (fwd1_hit),
        .fwd1_data (fwd1_data),
        .fwd2_hit  (fwd2_hit),
        .fwd2_data (fwd2_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance n active edges with the current inputs, settling 1 time unit after the last.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input logic [4:0] wa, input logic [31:0] wd);
        wb_req_t e;
        e.wa = wa;
        e.wd = wd;
        expQ.push_back(e);
    endtask

    // Every rf write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && rf_we) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual wa=%0d wd=0x%0h required=none", rf_wa, rf_wd);
            end else begin
                wb_req_t e;
                e = expQ.pop_front();
                checkOutput("mon_rf_wa", 32'(rf_wa), 32'(e.wa));
                checkOutput("mon_rf_wd", rf_wd, e.wd);
            end
        end
    end

    initial begin
        #1;
        checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("rst_rf_wa", 32'(rf_wa), 32'd0);
        checkOutput("rst_rf_wd", rf_wd, 32'd0);
        checkOutput("rst_late_ready", 32'(late_ready), 32'd1);
        checkOutput("rst_hazard", 32'(hazard), 32'd0);
        checkOutput("rst_drain_req", 32'(drain_req), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1);

        $display("[TB] reset mid-traffic");
        sb_set = 1'b1;
        sb_set_wa = 5'd12;
        applyStimulus(1);
        sb_set = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1;
            pipe_wa = 5'(i + 1);
            pipe_wd = 32'h100 + i;
            late_valid = 1'b1;
            late_wa = 5'(20 + i);
            late_wd = 32'h200 + i;
            expectWrite(5'(i + 1), 32'h100 + i);
            applyStimulus(1);
        end
        late_valid = 1'b0;
        @(negedge clk);
        #1;
        q_ra1 = 5'd12;
        #1;
        checkOutput("pre_rst_hazard", 32'(hazard), 32'd1);
        checkOutput("pre_rst_rf_we", 32'(rf_we), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("midrst_hazard", 32'(hazard), 32'd0);
        checkOutput("midrst_late_ready", 32'(late_ready), 32'd1);
        pipe_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(5);
        checkOutput("post_rst_rf_we", 32'(rf_we), 32'd0);
        checkOutput("post_rst_hazard", 32'(hazard), 32'd0);
        checkOutput("post_rst_late_ready", 32'(late_ready), 32'd1);
        checkOutput("post_rst_drain_req", 32'(drain_req), 32'd0);
        q_ra1 = '0;

        $display("[TB] pipeline write");
        pipe_we = 1'b1;
        pipe_wa = 5'd5;
        pipe_wd = 32'hDEADBEEF;
        expectWrite(5'd5, 32'hDEADBEEF);
        applyStimulus(1);
        checkOutput("pipe_rf_we", 32'(rf_we), 32'd1);
        pipe_wa = 5'd0;
        pipe_wd = 32'h55;
        applyStimulus(1);
        pipe_we = 1'b0;
        checkOutput("x0_rf_we", 32'(rf_we), 32'd0);
        checkOutput("idle_hold_wa", 32'(rf_wa), 32'd5);
        checkOutput("idle_hold_wd", rf_wd, 32'hDEADBEEF);

        $display("[TB] dispatch and late result");
        sb_set = 1'b1;
        sb_set_wa = 5'd7;
        applyStimulus(1);
        sb_set = 1'b0;
        q_ra1 = 5'd7;
        #1;
        checkOutput("sb_hazard_set", 32'(hazard), 32'd1);
        late_valid = 1'b1;
        late_wa = 5'd7;
        late_wd = 32'h1234;
        expectWrite(5'd7, 32'h1234);
        applyStimulus(1);
        late_valid = 1'b0;
        checkOutput("late_push_rf_we", 32'(rf_we), 32'd0);
        checkOutput("late_push_hazard", 32'(hazard), 32'd1);
        applyStimulus(1);
        checkOutput("late_pop_rf_we", 32'(rf_we), 32'd1);
        checkOutput("late_pop_hazard", 32'(hazard), 32'd0);
        q_ra1 = '0;

        $display("[TB] fifo fill under pipeline pressure");
        for (int i = 0; i < 4; i++) begin
            pipe_we = 1'b1;
            pipe_wa = 5'(i + 1);
            pipe_wd = 32'h3000 + i;
            late_valid = 1'b1;
            late_wa = 5'(16 + i);
            late_wd = 32'h4000 + i;
            expectWrite(5'(i + 1), 32'h3000 + i);
            applyStimulus(1);
        end
        checkOutput("full_late_ready", 32'(late_ready), 32'd0);
        checkOutput("full_drain_req", 32'(drain_req), 32'd1);
        pipe_we = 1'b0;
        late_wa = 5'd25;
        late_wd = 32'hBAD;
        expectWrite(5'd16, 32'h4000);
        applyStimulus(1);
        late_valid = 1'b0;
        checkOutput("bubble_rf_wa", 32'(rf_wa), 32'd16);
        checkOutput("bubble_late_ready", 32'(late_ready), 32'd1);
        checkOutput("bubble_drain_req", 32'(drain_req), 32'd0);
        for (int i = 1; i < 4; i++) begin
            expectWrite(5'(16 + i), 32'h4000 + i);
            applyStimulus(1);
        end
        applyStimulus(1);
        checkOutput("drained_rf_we", 32'(rf_we), 32'd0);

        $display("[TB] same-edge set and clear");
        sb_set = 1'b1;
        sb_set_wa = 5'd9;
        applyStimulus(1);
        sb_set = 1'b0;
        late_valid = 1'b1;
        late_wa = 5'd9;
        late_wd = 32'h99;
        expectWrite(5'd9, 32'h99);
        applyStimulus(1);
        late_valid = 1'b0;
        sb_set = 1'b1;
        sb_set_wa = 5'd9;
        applyStimulus(1);
        sb_set = 1'b0;
        q_wa = 5'd9;
        #1;
        checkOutput("set_wins_hazard", 32'(hazard), 32'd1);
        late_valid = 1'b1;
        late_wa = 5'd9;
        late_wd = 32'h9A;
        expectWrite(5'd9, 32'h9A);
        applyStimulus(1);
        late_valid = 1'b0;
        applyStimulus(1);
        checkOutput("set_cleared_hazard", 32'(hazard), 32'd0);
        q_wa = '0;

        $display("[TB] forwarding");
        q_ra1 = 5'd3;
        q_ra2 = 5'd3;
        pipe_we = 1'b1;
        pipe_wa = 5'd3;
        pipe_wd = 32'hAA;
        expectWrite(5'd3, 32'hAA);
        applyStimulus(1);
        pipe_we = 1'b0;
`ifdef WB_BYPASS_EN
        checkOutput("fwd2_hit", 32'(fwd2_hit), 32'd1);
        checkOutput("fwd2_data", fwd2_data, 32'hAA);
        checkOutput("fwd1_hit", 32'(fwd1_hit), 32'd1);
`else
        checkOutput("fwd2_hit", 32'(fwd2_hit), 32'd0);
        checkOutput("fwd2_data", fwd2_data, 32'd0);
        checkOutput("fwd1_hit", 32'(fwd1_hit), 32'd0);
`endif
        applyStimulus(1);
        checkOutput("fwd2_idle_hit", 32'(fwd2_hit), 32'd0);

        applyStimulus(3);
        checkOutput("exp_queue_empty", 32'(expQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
